// File: rtl/wash_pkg.sv
// wash_pkg: shared state encoding and fault codes for the washing-machine sequencer
package wash_pkg;
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FILL    = 4'd1,
        ADD_DET = 4'd2,
        AGITATE = 4'd3,
        DRAIN   = 4'd4,
        SPIN    = 4'd5,
        DONE    = 4'd6,
        ERROR   = 4'd7
    } state_t;
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_FILL  = 2'b01;
    localparam logic [1:0] ERR_DRAIN = 2'b10;
    localparam logic [1:0] ERR_DOOR  = 2'b11;
endpackage

// File: rtl/wash_timer.sv
// wash_timer: saturating cycle counter with clear and compare against a selected limit
module wash_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [TW-1:0] limit,
    output logic          hit
);
    logic [TW-1:0] count;
    // count cycles in the current state, restart on state change, hold at all-ones
    always_ff @(posedge clk) begin
        if (!reset || clr) count <= '0;
        else if (count != '1) count <= count + TW'(1);
    end
    assign hit = count == limit;
endmodule

// File: rtl/wash_ctrl_gen2.sv
// wash_ctrl_gen2: soap/rinse/spin washing-machine sequencer with watchdogs and fault handling
module wash_ctrl_gen2
    import wash_pkg::*;
#(
    parameter int TW        = 16,
    parameter int WASH_CYC  = 1000,
    parameter int SPIN_CYC  = 500,
    parameter int FILL_TMO  = 2000,
    parameter int DRAIN_TMO = 2000,
    parameter int RINSES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       door_close,
    input  logic       filled,
    input  logic       drained,
    input  logic       detergent_added,
    input  logic       abort,
    output logic       door_lock,
    output logic       motor_on,
    output logic       fill_valve_on,
    output logic       drain_valve_on,
    output logic       soap_wash,
    output logic       water_wash,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic [3:0] state_o,
    output logic [2:0] pass_o
);
    localparam logic [TW-1:0] FILL_LIM  = TW'(FILL_TMO - 1);
    localparam logic [TW-1:0] WASH_LIM  = TW'(WASH_CYC - 1);
    localparam logic [TW-1:0] DRAIN_LIM = TW'(DRAIN_TMO - 1);
    localparam logic [TW-1:0] SPIN_LIM  = TW'(SPIN_CYC - 1);
    localparam logic [2:0]    RIN       = 3'(RINSES);

    state_t        state, nxt;
    logic [2:0]    pass, pass_n;
    logic [1:0]    code, code_n;
    logic [TW-1:0] limit;
    logic          hit, active;

    assign active = state inside {FILL, ADD_DET, AGITATE, DRAIN, SPIN};
    assign limit  = state == FILL    ? FILL_LIM  :
                    state == AGITATE ? WASH_LIM  :
                    state == DRAIN   ? DRAIN_LIM : SPIN_LIM;

    wash_timer #(.TW(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (nxt != state),
        .limit (limit),
        .hit   (hit)
    );

    // state, pass index and latched fault code
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            pass  <= '0;
            code  <= ERR_NONE;
        end else begin
            state <= nxt;
            pass  <= pass_n;
            code  <= code_n;
        end
    end

    // sequencing; door/abort fault in an active state overrides everything else
    always_comb begin
        nxt    = state;
        pass_n = pass;
        code_n = code;
        case (state)
            IDLE:    if (start && door_close) begin
                         nxt    = FILL;
                         pass_n = '0;
                     end
            FILL:    if (filled) nxt = (pass == '0) ? ADD_DET : AGITATE;
                     else if (hit) begin
                         nxt    = ERROR;
                         code_n = ERR_FILL;
                     end
            ADD_DET: if (detergent_added) nxt = AGITATE;
            AGITATE: if (hit) nxt = DRAIN;
            DRAIN:   if (drained) begin
                         nxt    = (pass < RIN) ? FILL : SPIN;
                         pass_n = (pass < RIN) ? pass + 3'd1 : pass;
                     end else if (hit) begin
                         nxt    = ERROR;
                         code_n = ERR_DRAIN;
                     end
            SPIN:    if (hit) nxt = DONE;
            DONE:    if (!start) begin
                         nxt    = IDLE;
                         pass_n = '0;
                     end
            ERROR:   if (drained && !start && abort) begin
                         nxt    = IDLE;
                         pass_n = '0;
                         code_n = ERR_NONE;
                     end
            default: begin
                         nxt    = IDLE;
                         pass_n = '0;
                     end
        endcase
        if (active && (abort || !door_close)) begin
            nxt    = ERROR;
            pass_n = pass;
            code_n = ERR_DOOR;
        end
    end

    assign door_lock      = active || (state == ERROR && !drained);
    assign motor_on       = state == AGITATE || state == SPIN;
    assign fill_valve_on  = state == FILL;
    assign drain_valve_on = state == DRAIN || state == SPIN || (state == ERROR && !drained);
    assign soap_wash      = active && pass == '0;
    assign water_wash     = active && pass != '0;
    assign done           = state == DONE;
    assign error          = state == ERROR;
    assign err_code       = code;
    assign state_o        = state;
    assign pass_o         = pass;
endmodule

// File: tb/tb_wash_ctrl_gen2.sv
// tb_wash_ctrl_gen2: directed self-checking bench for the washing-machine sequencer
module tb_wash_ctrl_gen2;
    logic clk = 0, reset_a = 0, reset_b = 0;
    logic start = 0, door_close = 0, filled = 0, drained = 0, det = 0, abort = 0;
    logic a_lock, a_motor, a_fill, a_drain, a_soap, a_water, a_done, a_error;
    logic [1:0] a_code;
    logic [3:0] a_state;
    logic [2:0] a_pass;
    logic b_lock, b_motor, b_fill, b_drain, b_soap, b_water, b_done, b_error;
    logic [1:0] b_code;
    logic [3:0] b_state;
    logic [2:0] b_pass;
    logic wseen = 0;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    wash_ctrl_gen2 #(.TW(16), .WASH_CYC(4), .SPIN_CYC(3), .FILL_TMO(5), .DRAIN_TMO(6), .RINSES(2)) dut_a (
        .clk(clk), .reset(reset_a), .start(start), .door_close(door_close), .filled(filled),
        .drained(drained), .detergent_added(det), .abort(abort),
        .door_lock(a_lock), .motor_on(a_motor), .fill_valve_on(a_fill), .drain_valve_on(a_drain),
        .soap_wash(a_soap), .water_wash(a_water), .done(a_done), .error(a_error),
        .err_code(a_code), .state_o(a_state), .pass_o(a_pass));

    wash_ctrl_gen2 #(.TW(16), .WASH_CYC(4), .SPIN_CYC(3), .FILL_TMO(5), .DRAIN_TMO(6), .RINSES(0)) dut_b (
        .clk(clk), .reset(reset_b), .start(start), .door_close(door_close), .filled(filled),
        .drained(drained), .detergent_added(det), .abort(abort),
        .door_lock(b_lock), .motor_on(b_motor), .fill_valve_on(b_fill), .drain_valve_on(b_drain),
        .soap_wash(b_soap), .water_wash(b_water), .done(b_done), .error(b_error),
        .err_code(b_code), .state_o(b_state), .pass_o(b_pass));

    always @(negedge clk) if (b_water) wseen = 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [16:0] a_all();
        return {a_lock, a_motor, a_fill, a_drain, a_soap, a_water, a_done, a_error, a_code, a_state, a_pass};
    endfunction

    task automatic do_pass(input logic [2:0] p, input logic [3:0] after);
        chk("fill_state", a_state, 1);
        chk("fill_pass", a_pass, p);
        chk("fill_valve", a_fill, 1);
        chk("fill_lock", a_lock, 1);
        chk("soap_wash", a_soap, p == 0);
        chk("water_wash", a_water, p != 0);
        step(1); filled = 1; step(1); filled = 0;
        if (p == 0) begin
            chk("add_det_state", a_state, 2);
            chk("add_det_act", {a_motor, a_fill, a_drain}, 0);
            step(1); det = 1; step(1); det = 0;
        end
        chk("agitate_state", a_state, 3);
        chk("agitate_motor", a_motor, 1);
        step(3);
        chk("agitate_hold", a_state, 3);
        step(1);
        chk("drain_state", a_state, 4);
        chk("drain_valve", {a_motor, a_drain}, 2'b01);
        step(1); drained = 1; step(1); drained = 0;
        chk("after_drain", a_state, after);
    endtask

    initial begin
        step(2);
        chk("reset_outputs", a_all(), 0);
        reset_a = 1;
        step(1);
        chk("idle_hold", a_state, 0);

        start = 1; door_close = 1;
        step(1);
        do_pass(0, 1);
        do_pass(1, 1);
        do_pass(2, 5);
        chk("spin_act", {a_motor, a_drain, a_pass}, {2'b11, 3'd2});
        step(2);
        chk("spin_hold", a_state, 5);
        step(1);
        chk("done_state", {a_state, a_done, a_lock}, {4'd6, 2'b10});
        step(2);
        chk("done_hold", a_state, 6);
        start = 0;
        step(1);
        chk("done_to_idle", {a_state, a_pass}, 0);

        start = 1;
        step(1);
        start = 0;
        chk("tmo_fill", a_state, 1);
        step(4);
        chk("tmo_fill_hold", a_state, 1);
        step(1);
        chk("tmo_error", {a_state, a_code, a_error, a_drain, a_lock, a_motor}, {4'd7, 2'b01, 4'b1110});
        abort = 1;
        step(1);
        abort = 0;
        chk("tmo_code_kept", {a_state, a_code}, {4'd7, 2'b01});
        drained = 1;
        #1;
        chk("tmo_unlock", {a_lock, a_drain, a_error}, 3'b001);
        step(1);
        chk("tmo_err_hold", a_state, 7);
        abort = 1;
        step(1);
        chk("tmo_exit", {a_state, a_code}, 0);
        abort = 0; drained = 0;

        start = 1;
        step(1);
        start = 0;
        step(4);
        filled = 1;
        step(1);
        filled = 0;
        chk("fill_wins", {a_state, a_error, a_code}, {4'd2, 3'b000});
        det = 1;
        step(1);
        det = 0;
        step(1);
        chk("door_agitate", a_state, 3);
        door_close = 0;
        step(1);
        chk("door_error", {a_state, a_code, a_motor, a_drain, a_lock}, {4'd7, 2'b11, 3'b011});
        door_close = 1; drained = 1; abort = 1;
        step(1);
        chk("door_exit", {a_state, a_code}, 0);
        drained = 0; abort = 0;

        start = 1;
        step(1);
        start = 0; filled = 1;
        step(1);
        filled = 0; det = 1;
        step(1);
        det = 0;
        step(4);
        chk("abort_drain", a_state, 4);
        abort = 1; drained = 1;
        step(1);
        chk("abort_beats_drained", {a_state, a_code}, {4'd7, 2'b11});
        step(1);
        chk("abort_exit", a_state, 0);
        abort = 0; drained = 0;

        start = 1;
        step(1);
        do_pass(0, 1);
        do_pass(1, 1);
        do_pass(2, 5);
        step(1);
        chk("reset_spin_pre", a_state, 5);
        reset_a = 0;
        step(1);
        chk("reset_mid_spin", a_all(), 0);
        step(1);
        chk("reset_ignores_start", a_all(), 0);
        start = 0;

        reset_b = 1;
        step(1);
        start = 1;
        step(1);
        start = 0;
        chk("r0_fill", b_state, 1);
        filled = 1;
        step(1);
        filled = 0; det = 1;
        step(1);
        det = 0;
        chk("r0_agitate", b_state, 3);
        step(4);
        chk("r0_drain", b_state, 4);
        drained = 1;
        step(1);
        drained = 0;
        chk("r0_spin", {b_state, b_pass, b_soap, b_motor, b_drain}, {4'd5, 3'd0, 3'b111});
        step(3);
        chk("r0_done", {b_state, b_done}, {4'd6, 1'b1});
        chk("r0_no_water", wseen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
